// File: rtl/ioctl_word_packer.sv
// Word FIFO for the packer: registered storage, head visible while !empty.
// Latency: a push is visible at dout the cycle after the write edge.
// Backpressure: a push is accepted when not full or when a pop happens in the same cycle.
module ioctl_word_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign do_rd = pop & ~empty;
    assign do_wr = push & (~full | do_rd);
    assign dout  = mem[rptr];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_wr) mem[wptr] <= din;
    end
endmodule

// Packs the byte-wide ioctl download stream into byte-enabled memory words.
// Latency: a completed word is queued at the edge that samples ioctl_wr; mem_req rises the next cycle.
// Backpressure: ioctl_wait registered from FIFO count (>= DEPTH-1); words pushed into a full FIFO are dropped and flag overflow.
module ioctl_word_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int BIG_ENDIAN = 0
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      ioctl_download,
    input  logic                      ioctl_wr,
    input  logic [24:0]               ioctl_addr,
    input  logic [7:0]                ioctl_dout,
    output logic                      ioctl_wait,
    output logic                      mem_req,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_data,
    output logic [DATA_WIDTH/8-1:0]   mem_be,
    input  logic                      mem_ack,
    output logic                      overflow,
    output logic                      busy
);
    localparam int BPW  = DATA_WIDTH / 8;
    localparam int OFFS = $clog2(BPW);
    localparam int OFFW = (OFFS > 0) ? OFFS : 1;
    localparam int EW   = ADDR_WIDTH + DATA_WIDTH + BPW;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;

    logic                  dl_q;
    logic                  dl_rise;
    logic                  dl_fall;
    logic                  wr_en;

    logic                  asm_vld;
    logic [ADDR_WIDTH-1:0] asm_addr;
    logic [DATA_WIDTH-1:0] asm_dat;
    logic [BPW-1:0]        asm_be;
    logic                  flush_pend;

    logic [OFFW-1:0]       off;
    logic [OFFW-1:0]       lane;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] lane_dat;
    logic [DATA_WIDTH-1:0] lane_msk;
    logic [BPW-1:0]        lane_be;
    logic                  same_word;
    logic [DATA_WIDTH-1:0] mrg_dat;
    logic [BPW-1:0]        mrg_be;
    logic                  disc_push;
    logic                  cmpl_push;
    logic                  flush_push;

    logic                  push;
    logic [EW-1:0]         push_dat;
    logic                  pop;
    logic                  drop;
    logic [EW-1:0]         head;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CW-1:0]         fifo_count;
    logic                  wait_q;
    logic                  ovf_q;

    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;
    assign wr_en   = ioctl_wr & ioctl_download;

    // Byte lane placement; a rising download edge makes the assembly look empty.
    always_comb begin
        off       = ioctl_addr[OFFW-1:0] & OFFW'(BPW - 1);
        lane      = (BIG_ENDIAN != 0) ? (OFFW'(BPW - 1) - off) : off;
        waddr     = ADDR_WIDTH'(ioctl_addr >> OFFS);
        lane_dat  = DATA_WIDTH'(ioctl_dout) << {lane, 3'b000};
        lane_msk  = DATA_WIDTH'(8'hFF) << {lane, 3'b000};
        lane_be   = BPW'(1) << lane;
        same_word = asm_vld & ~dl_rise & (asm_addr == waddr);
        mrg_dat   = lane_dat;
        mrg_be    = lane_be;
        if (same_word) begin
            mrg_dat = (asm_dat & ~lane_msk) | lane_dat;
            mrg_be  = asm_be | lane_be;
        end
        disc_push  = wr_en & asm_vld & ~dl_rise & ~same_word;
        cmpl_push  = wr_en & (mrg_be == {BPW{1'b1}});
        flush_push = flush_pend & asm_vld & ~ioctl_download & (~fifo_full | pop);
    end

    // At most one push source per cycle: a fresh byte cannot complete a multi-byte word.
    always_comb begin
        push     = disc_push | cmpl_push | flush_push;
        push_dat = {asm_addr, asm_dat, asm_be};
        if (!disc_push && cmpl_push) begin
            push_dat = {waddr, mrg_dat, mrg_be};
        end
        pop  = ~fifo_empty & mem_ack;
        drop = push & fifo_full & ~pop;
    end

    ioctl_word_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (push),
        .din     (push_dat),
        .pop     (pop),
        .dout    (head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_q       <= 1'b0;
            wait_q     <= 1'b0;
            ovf_q      <= 1'b0;
            asm_vld    <= 1'b0;
            asm_addr   <= '0;
            asm_dat    <= '0;
            asm_be     <= '0;
            flush_pend <= 1'b0;
        end else begin
            dl_q   <= ioctl_download;
            wait_q <= (fifo_count >= CW'(FIFO_DEPTH - 1));

            if (drop) begin
                ovf_q <= 1'b1;
            end else if (dl_rise) begin
                ovf_q <= 1'b0;
            end

            if (wr_en) begin
                if (cmpl_push) begin
                    asm_vld <= 1'b0;
                end else begin
                    asm_vld  <= 1'b1;
                    asm_addr <= waddr;
                    asm_dat  <= mrg_dat;
                    asm_be   <= mrg_be;
                end
            end else if (dl_rise || flush_push) begin
                asm_vld <= 1'b0;
            end

            if (dl_rise) begin
                flush_pend <= 1'b0;
            end else if (dl_fall && asm_vld) begin
                flush_pend <= 1'b1;
            end else if (flush_push || !asm_vld) begin
                flush_pend <= 1'b0;
            end
        end
    end

    assign ioctl_wait = wait_q;
    assign overflow   = ovf_q;
    assign mem_req    = ~fifo_empty;
    assign {mem_addr, mem_data, mem_be} = fifo_empty ? '0 : head;
    assign busy       = ioctl_download | asm_vld | flush_pend | ~fifo_empty;
endmodule

// File: tb/tb_ioctl_word_packer.sv
// Directed bench: instance A (16-bit LE, depth 4), instance B (32-bit BE, depth 8).
module tb_ioctl_word_packer;
    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset;

    logic        a_dl, a_wr, a_ack;
    logic [24:0] a_addr;
    logic [7:0]  a_dout;
    logic        a_wait, a_req, a_ovf, a_busy;
    logic [23:0] a_maddr;
    logic [15:0] a_mdata;
    logic [1:0]  a_mbe;

    logic        b_dl, b_wr, b_ack;
    logic [24:0] b_addr;
    logic [7:0]  b_dout;
    logic        b_wait, b_req, b_ovf, b_busy;
    logic [23:0] b_maddr;
    logic [31:0] b_mdata;
    logic [3:0]  b_mbe;

    ioctl_word_packer #(.DATA_WIDTH(16), .ADDR_WIDTH(24), .FIFO_DEPTH(4), .BIG_ENDIAN(0)) dut_a (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(a_dl), .ioctl_wr(a_wr),
        .ioctl_addr(a_addr), .ioctl_dout(a_dout), .ioctl_wait(a_wait), .mem_req(a_req),
        .mem_addr(a_maddr), .mem_data(a_mdata), .mem_be(a_mbe), .mem_ack(a_ack),
        .overflow(a_ovf), .busy(a_busy)
    );

    ioctl_word_packer #(.DATA_WIDTH(32), .ADDR_WIDTH(24), .FIFO_DEPTH(8), .BIG_ENDIAN(1)) dut_b (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(b_dl), .ioctl_wr(b_wr),
        .ioctl_addr(b_addr), .ioctl_dout(b_dout), .ioctl_wait(b_wait), .mem_req(b_req),
        .mem_addr(b_maddr), .mem_data(b_mdata), .mem_be(b_mbe), .mem_ack(b_ack),
        .overflow(b_ovf), .busy(b_busy)
    );

    typedef struct packed {
        logic [23:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } word_t;

    word_t exp_a[$];
    word_t exp_b[$];
    word_t wa, wb;
    int    checks = 0;
    int    errors = 0;
    int    a_pops = 0;
    int    b_pops = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: compare the head word whenever it is accepted.
    always @(negedge clk_sys) begin
        if (!reset && a_req && a_ack) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_word: got addr %0h data %0h be %0h expected none", a_maddr, a_mdata, a_mbe);
            end else begin
                wa = exp_a.pop_front();
                check("a_addr", a_maddr, wa.addr);
                check("a_data", a_mdata, wa.data);
                check("a_be", a_mbe, wa.be);
            end
            a_pops++;
        end
        if (!reset && b_req && b_ack) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_word: got addr %0h data %0h be %0h expected none", b_maddr, b_mdata, b_mbe);
            end else begin
                wb = exp_b.pop_front();
                check("b_addr", b_maddr, wb.addr);
                check("b_data", b_mdata, wb.data);
                check("b_be", b_mbe, wb.be);
            end
            b_pops++;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wr_a(input logic [24:0] ad, input logic [7:0] d);
        a_addr = ad;
        a_dout = d;
        a_wr   = 1'b1;
        tick();
        a_wr   = 1'b0;
    endtask

    task automatic wr_b(input logic [24:0] ad, input logic [7:0] d);
        b_addr = ad;
        b_dout = d;
        b_wr   = 1'b1;
        tick();
        b_wr   = 1'b0;
    endtask

    task automatic exp_push_a(input logic [23:0] ad, input logic [15:0] d, input logic [1:0] be);
        word_t w;
        w.addr = ad;
        w.data = {16'h0, d};
        w.be   = {2'b00, be};
        exp_a.push_back(w);
    endtask

    task automatic exp_push_b(input logic [23:0] ad, input logic [31:0] d, input logic [3:0] be);
        word_t w;
        w.addr = ad;
        w.data = d;
        w.be   = be;
        exp_b.push_back(w);
    endtask

    task automatic drain_a(input int n, input string name);
        int start;
        start = a_pops;
        a_ack = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (a_pops >= start + n) break;
            tick();
        end
        a_ack = 1'b0;
        check(name, 64'(a_pops - start), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        a_dl = 0; a_wr = 0; a_addr = '0; a_dout = '0; a_ack = 0;
        b_dl = 0; b_wr = 0; b_addr = '0; b_dout = '0; b_ack = 1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst_a_req", a_req, 0);
        check("rst_a_addr", a_maddr, 0);
        check("rst_a_data", a_mdata, 0);
        check("rst_a_be", a_mbe, 0);
        check("rst_a_ovf", a_ovf, 0);
        check("rst_a_wait", a_wait, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_b_req", b_req, 0);

        // Two bytes complete one word.
        a_dl = 1'b1;
        tick();
        wr_a(25'd0, 8'h11);
        check("t1_req_after_first", a_req, 0);
        wr_a(25'd1, 8'h22);
        exp_push_a(24'd0, 16'h2211, 2'b11);
        check("t1_req_after_second", a_req, 1);
        drain_a(1, "t1_drain");
        check("t1_req_idle", a_req, 0);

        // Gap, completion, lane rewrite, partial flush.
        wr_a(25'd0, 8'h33);
        wr_a(25'd6, 8'h44);
        exp_push_a(24'd0, 16'h0033, 2'b01);
        check("t3_gap_req", a_req, 1);
        wr_a(25'd7, 8'h55);
        exp_push_a(24'd3, 16'h5544, 2'b11);
        wr_a(25'd8, 8'h66);
        wr_a(25'd8, 8'h77);
        wr_a(25'd9, 8'h88);
        exp_push_a(24'd4, 16'h8877, 2'b11);
        wr_a(25'h0B, 8'h99);
        exp_push_a(24'd5, 16'h9900, 2'b10);
        a_dl = 1'b0;
        drain_a(4, "t3_drain");
        tick();
        check("t3_busy_idle", a_busy, 0);
        wr_a(25'h20, 8'hEE);
        tick();
        check("wr_ignored_req", a_req, 0);
        check("wr_ignored_busy", a_busy, 0);

        // Fill depth-4 FIFO with no acks, then overflow.
        a_dl = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            wr_a(25'(2 * k), 8'(2 * k));
            wr_a(25'(2 * k + 1), 8'(2 * k + 1));
            exp_push_a(24'(k), {8'(2 * k + 1), 8'(2 * k)}, 2'b11);
            if (k == 2) check("t4_wait_lag", a_wait, 0);
            if (k == 3) check("t4_wait_set", a_wait, 1);
        end
        check("t4_no_ovf_yet", a_ovf, 0);
        wr_a(25'd8, 8'h08);
        wr_a(25'd9, 8'h09);
        check("t4_overflow", a_ovf, 1);
        check("t4_req", a_req, 1);
        check("t4_head_addr", a_maddr, 0);

        // Rising edge clears overflow; push+pop while full.
        a_dl = 1'b0;
        tick();
        a_dl = 1'b1;
        tick();
        check("t5_ovf_cleared", a_ovf, 0);
        wr_a(25'd10, 8'h0A);
        a_ack = 1'b1;
        wr_a(25'd11, 8'h0B);
        a_ack = 1'b0;
        exp_push_a(24'd5, 16'h0B0A, 2'b11);
        check("t5_no_ovf", a_ovf, 0);
        drain_a(4, "t5_drain_four");
        tick();
        check("t5_req_empty", a_req, 0);
        check("t5_wait_clear", a_wait, 0);

        // Instance B: big-endian full word, then partial flush.
        b_dl = 1'b1;
        tick();
        wr_b(25'd8, 8'h01);
        wr_b(25'd9, 8'h02);
        wr_b(25'd10, 8'h03);
        wr_b(25'd11, 8'h04);
        exp_push_b(24'd2, 32'h01020304, 4'hF);
        wr_b(25'd4, 8'hAA);
        wr_b(25'd5, 8'hBB);
        exp_push_b(24'd1, 32'hAABB0000, 4'b1100);
        b_dl = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (b_pops >= 2) break;
            tick();
        end
        check("t2_b_pops", 64'(b_pops), 2);
        tick();
        check("t2_b_busy", b_busy, 0);

        // Reset mid-download with three words queued and a partial assembly.
        for (int k = 0; k < 6; k++) wr_a(25'(16 + k), 8'(k));
        wr_a(25'd30, 8'h5A);
        check("t6_req_before", a_req, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_req", a_req, 0);
        check("t6_busy", a_busy, 1);
        check("t6_ovf", a_ovf, 0);
        check("t6_data", a_mdata, 0);
        a_dl = 1'b0;
        repeat (4) tick();
        check("t6_no_flush", a_req, 0);
        check("t6_busy_idle", a_busy, 0);

        check("a_queue_empty", 64'(exp_a.size()), 0);
        check("b_queue_empty", 64'(exp_b.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
